// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI mode-0 responder, oversampled in the clk domain, with a single-entry TX buffer and RX word strobe.
module spi_slave_core #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int MSB_FIRST   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  busy
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t                  state, state_nx;
   logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
   logic                    sclk_s, cs_n_s, mosi_s, sclk_q, cs_q;
   logic                    rise, fall, cs_fall, cs_rise;
   logic [CW-1:0]           bit_cnt;
   logic [DATA_WIDTH-1:0]   tx_shift, rx_shift, buf_data, ld_word, tx_next, rx_next;
   logic                    buf_full, load, shift_fall, shift_rise, wr;

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign cs_n_s  = cs_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_q;
   assign fall    = ~sclk_s & sclk_q;
   assign cs_fall = ~cs_n_s & cs_q;
   assign cs_rise = cs_n_s & ~cs_q;
   assign busy    = ~cs_n_s;
   assign tx_ready = ~buf_full;
   assign wr      = tx_valid & ~buf_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_q    <= sclk_s;
         cs_q      <= cs_n_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = cs_rise ? IDLE :
                 (state == IDLE && cs_fall) ? LOAD :
                 (state == LOAD) ? SHIFT : state;
   end

   // a fall with a cleared bit counter follows a completed word and starts the next one
   assign shift_fall = (state == SHIFT) & fall;
   assign shift_rise = (state == SHIFT) & rise;
   assign load    = ~cs_rise & ((state == LOAD) | (shift_fall & (bit_cnt == '0)));
   assign ld_word = buf_full ? buf_data : '0;
   assign tx_next = (MSB_FIRST != 0) ? (tx_shift << 1) : (tx_shift >> 1);
   assign rx_next = (MSB_FIRST != 0) ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                     : {mosi_s, rx_shift[DATA_WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         buf_data    <= '0;
         buf_full    <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         buf_full    <= wr | (buf_full & ~load);
         if (wr) buf_data <= tx_data;
         if (cs_rise) begin
            bit_cnt <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end else begin
            if (load) begin
               tx_shift    <= ld_word;
               miso        <= (MSB_FIRST != 0) ? ld_word[DATA_WIDTH-1] : ld_word[0];
               miso_oe     <= 1'b1;
               tx_underrun <= ~buf_full;
            end else if (shift_fall) begin
               tx_shift <= tx_next;
               miso     <= (MSB_FIRST != 0) ? tx_next[DATA_WIDTH-1] : tx_next[0];
            end
            if (shift_rise) begin
               rx_shift <= rx_next;
               if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                  rx_data  <= rx_next;
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: random and directed SPI frames against MSB-first and LSB-first instances, scoreboard-checked.
module tb_spi_slave_core;
   logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       miso_m, miso_oe_m, tx_ready_m, rx_valid_m, tx_underrun_m, busy_m;
   logic       miso_l, miso_oe_l, tx_ready_l, rx_valid_l, tx_underrun_l, busy_l;
   logic [7:0] rx_data_m, rx_data_l;

   int compared = 0, mismatched = 0;
   int und_exp = 0, und_got_m = 0, und_got_l = 0;
   logic [7:0] exp_rx_m[$], exp_rx_l[$];
   bit         mdl_full = 1'b0;
   logic [7:0] mdl_buf = '0;

   always #5 clk = ~clk;

   spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso_m), .miso_oe(miso_oe_m), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m),
      .tx_underrun(tx_underrun_m), .busy(busy_m));

   spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso_l), .miso_oe(miso_oe_l), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
      .tx_underrun(tx_underrun_l), .busy(busy_l));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // the master sends MSB first, so the LSB-first instance sees every word bit-reversed
   always @(negedge clk) begin
      if (rx_valid_m) begin
         if (exp_rx_m.size() == 0) chk("rx_unexpected_m", 32'(rx_data_m), 32'hFFFF_FFFF);
         else chk("rx_data_m", 32'(rx_data_m), 32'(exp_rx_m.pop_front()));
      end
      if (rx_valid_l) begin
         if (exp_rx_l.size() == 0) chk("rx_unexpected_l", 32'(rx_data_l), 32'hFFFF_FFFF);
         else chk("rx_data_l", 32'(rx_data_l), 32'(exp_rx_l.pop_front()));
      end
      if (tx_underrun_m) und_got_m++;
      if (tx_underrun_l) und_got_l++;
   end

   task automatic load_word(output logic [7:0] w);
      if (mdl_full) begin
         w = mdl_buf;
         mdl_full = 1'b0;
      end else begin
         w = '0;
         und_exp++;
      end
   endtask

   task automatic tx_write(input logic [7:0] d);
      chk("tx_ready_m", 32'(tx_ready_m), 32'(!mdl_full));
      chk("tx_ready_l", 32'(tx_ready_l), 32'(!mdl_full));
      if (!mdl_full) begin
         tx_data = d;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         mdl_full = 1'b1;
         mdl_buf = d;
      end
      @(negedge clk);
   endtask

   task automatic frame(input int nw, input int abort, input bit dir,
                        input logic [7:0] dmosi, input logic [7:0] wdata);
      logic [7:0] cur, w, got_m, got_l, mm, ml;
      int bits;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      load_word(cur);
      for (int wi = 0; wi < nw; wi++) begin
         w = dir ? dmosi : 8'($urandom);
         bits = (wi == nw - 1 && abort > 0) ? abort : 8;
         if (bits == 8) begin
            exp_rx_m.push_back(w);
            exp_rx_l.push_back(rev8(w));
         end
         got_m = '0;
         got_l = '0;
         for (int b = 0; b < bits; b++) begin
            mosi = w[7-b];
            repeat (4) @(negedge clk);
            got_m[7-b] = miso_m;
            got_l[b] = miso_l;
            if (b == 0) begin
               chk("busy", 32'(busy_m), 32'd1);
               chk("miso_oe", 32'(miso_oe_m), 32'd1);
            end
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (b == 2 && (dir ? (wi == 0 && nw > 1) : ($urandom_range(0, 1) == 1)))
               tx_write(dir ? wdata : 8'($urandom));
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
         end
         mm = 8'hFF << (8 - bits);
         ml = 8'hFF >> (8 - bits);
         chk("miso_word_m", 32'(got_m & mm), 32'(cur & mm));
         chk("miso_word_l", 32'(got_l & ml), 32'(cur & ml));
         if (bits == 8) load_word(cur);
      end
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("idle_miso_oe", 32'({miso_oe_m, miso_oe_l}), 32'd0);
      chk("idle_miso", 32'({miso_m, miso_l}), 32'd0);
      chk("idle_busy", 32'({busy_m, busy_l}), 32'd0);
      chk("rx_pending", 32'(exp_rx_m.size() + exp_rx_l.size()), 32'd0);
      chk("underrun_m", 32'(und_got_m), 32'(und_exp));
      chk("underrun_l", 32'(und_got_l), 32'(und_exp));
   endtask

   task automatic reset_mid();
      logic [7:0] cur;
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      load_word(cur);
      for (int b = 0; b < 3; b++) begin
         mosi = 1'($urandom);
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (8) @(negedge clk);
         if (b == 1) tx_write(8'($urandom));
         sclk = 1'b0;
         repeat (8) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk("rstmid_miso_oe", 32'({miso_oe_m, miso_oe_l}), 32'd0);
      chk("rstmid_tx_ready", 32'({tx_ready_m, tx_ready_l}), 32'd3);
      chk("rstmid_rx_valid", 32'({rx_valid_m, rx_valid_l}), 32'd0);
      chk("rstmid_miso_busy", 32'({miso_m, miso_l, busy_m, busy_l}), 32'd0);
      mdl_full = 1'b0;
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_miso", 32'({miso_m, miso_oe_m, miso_l, miso_oe_l}), 32'd0);
      chk("rst_tx_ready", 32'({tx_ready_m, tx_ready_l}), 32'd3);
      chk("rst_rx_data", 32'({rx_data_m, rx_data_l}), 32'd0);
      chk("rst_strobes", 32'({rx_valid_m, tx_underrun_m, rx_valid_l, tx_underrun_l}), 32'd0);
      chk("rst_busy", 32'({busy_m, busy_l}), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tx_write(8'hA5);
      frame(1, 0, 1'b1, 8'h3C, 8'h00);
      tx_write(8'h11);
      frame(2, 0, 1'b1, 8'h5A, 8'h22);
      frame(1, 0, 1'b1, 8'hC3, 8'h00);
      tx_write(8'h77);
      frame(1, 5, 1'b1, 8'h00, 8'h00);
      frame(1, 0, 1'b1, 8'hFF, 8'h00);
      reset_mid();
      tx_write(8'h01);
      frame(1, 0, 1'b1, 8'h01, 8'h00);
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
         frame($urandom_range(1, 3), ($urandom_range(0, 9) < 3) ? $urandom_range(1, 7) : 0,
               1'b0, 8'h00, 8'h00);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
